// File: rtl/window3x3_linebuf.sv
// window3x3_linebuf: raster-stream 3x3 window generator over two line buffers; define WINDOW_STRIDE2_EN for stride-2 windows
module window3x3_linebuf #(
    parameter int DWIDTH = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DWIDTH-1:0]   in_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [9*DWIDTH-1:0] win_data,
    output logic                frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    typedef enum logic {FILL, STREAM} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [DWIDTH-1:0] lb0 [IMG_W];
    logic [DWIDTH-1:0] lb1 [IMG_W];
    logic [9*DWIDTH-1:0] win_nxt;
    logic accept, col_last, row_last, emit;
    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = col == CW'(IMG_W - 1);
    assign row_last = row == RW'(IMG_H - 1);
`ifdef WINDOW_STRIDE2_EN
    assign emit = accept && state == STREAM && col >= CW'(2) && !col[0] && !row[0];
`else
    assign emit = accept && state == STREAM && col >= CW'(2);
`endif
    assign win_nxt = {in_data, win_data[8*DWIDTH +: DWIDTH], win_data[7*DWIDTH +: DWIDTH],
                      lb0[col], win_data[5*DWIDTH +: DWIDTH], win_data[4*DWIDTH +: DWIDTH],
                      lb1[col], win_data[2*DWIDTH +: DWIDTH], win_data[1*DWIDTH +: DWIDTH]};
    // FILL until both line buffers hold a row, STREAM until the frame's last pixel
    always_comb begin
        state_nxt = state;
        if (accept && col_last && state == FILL && row == RW'(1))
            state_nxt = STREAM;
        if (accept && col_last && state == STREAM && row_last)
            state_nxt = FILL;
    end
    // counters, window shift register and output handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= accept && row_last && col_last;
            win_valid  <= accept ? emit : win_valid && !win_ready;
            if (accept) begin
                win_data <= win_nxt;
                col      <= col_last ? '0 : col + 1'b1;
                if (col_last)
                    row <= row_last ? '0 : row + 1'b1;
            end
        end
    end
    // line buffers age one row per accepted pixel; contents are never cleared
    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= in_data;
        end
    end
endmodule

// File: tb/tb_window3x3_linebuf.sv
// tb_window3x3_linebuf: randomized and directed checks of window3x3_linebuf against an image-level model
module tb_window3x3_linebuf;
    localparam int DW = 8, W = 8, H = 8, NPIX = W * H;
`ifdef WINDOW_STRIDE2_EN
    localparam int WPF = ((W - 3) / 2 + 1) * ((H - 3) / 2 + 1);
    localparam logic [DW-1:0] LAST_C = 8'h2D;
`else
    localparam int WPF = (W - 2) * (H - 2);
    localparam logic [DW-1:0] LAST_C = 8'h36;
`endif
    logic clk = 0, rst_n = 0, in_valid = 0, win_ready = 1;
    logic in_ready, win_valid, frame_done;
    logic [DW-1:0] in_data = '0;
    logic [9*DW-1:0] win_data;
    int checks = 0, errors = 0;
    logic [DW-1:0] fr [H][W];
    logic [9*DW-1:0] expq [$];
    logic [9*DW-1:0] got [$];
    logic [9*DW-1:0] t1 [$];
    logic [9*DW-1:0] hold_data;
    bit exp_valid = 0, exp_fd = 0, hold_pend = 0;
    int pix = 0, acc_cnt = 0, dut_fd = 0;

    always #5 clk = ~clk;

    window3x3_linebuf #(.DWIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data), .frame_done(frame_done)
    );

    task automatic check(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit emits(input int r, input int c);
`ifdef WINDOW_STRIDE2_EN
        return r >= 2 && c >= 2 && (r - 2) % 2 == 0 && (c - 2) % 2 == 0;
`else
        return r >= 2 && c >= 2;
`endif
    endfunction

    function automatic logic [9*DW-1:0] window_at(input int r, input int c);
        logic [9*DW-1:0] w;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*DW +: DW] = fr[r-2+i][c-2+j];
        return w;
    endfunction

    task automatic step(input bit iv, input logic [DW-1:0] d, input bit wr);
        int r, c;
        bit acc;
        @(negedge clk);
        in_valid = iv; in_data = d; win_ready = wr;
        #1;
        check("win_valid", win_valid, exp_valid);
        check("frame_done", frame_done, exp_fd);
        check("in_ready", in_ready, !exp_valid || wr);
        if (frame_done) dut_fd++;
        if (hold_pend) check("win_hold", win_data, hold_data);
        hold_pend = win_valid && !wr;
        hold_data = win_data;
        if (win_valid && wr) begin
            check("win_avail", expq.size() != 0, 1);
            if (expq.size() != 0) check("win_data", win_data, expq.pop_front());
            got.push_back(win_data);
        end
        acc = iv && (!exp_valid || wr);
        exp_fd = 0;
        if (acc) begin
            r = pix / W; c = pix % W;
            fr[r][c] = d;
            exp_fd = pix == NPIX - 1;
            pix = (pix + 1) % NPIX;
            acc_cnt++;
            if (emits(r, c)) expq.push_back(window_at(r, c));
            exp_valid = emits(r, c);
        end else if (wr) begin
            exp_valid = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; in_valid = 0; win_ready = 1;
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_win_valid", win_valid, 0);
        check("rst_win_data", win_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_in_ready", in_ready, 1);
        exp_valid = 0; exp_fd = 0; pix = 0; hold_pend = 0;
        expq.delete();
    endtask

    task automatic run(input int npix, input int vmode, input int rmode, input bit rnd, input int budget);
        int start = acc_cnt, cyc = 0, stall = 0, n;
        bit stalled = 0, iv, wr;
        logic [DW-1:0] rd = DW'($urandom), d;
        while (acc_cnt - start < npix && cyc < budget) begin
            iv = vmode == 0 ? 1'b1 : vmode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (rmode == 1 && exp_valid && !stalled) begin
                stalled = 1;
                stall = 5;
            end
            wr = rmode == 2 ? ($urandom_range(0, 3) != 0) : stall == 0;
            if (stall > 0) stall--;
            n = acc_cnt - start;
            d = rnd ? rd : DW'(n % NPIX + 8'h40 * (n / NPIX));
            step(iv, d, wr);
            if (acc_cnt - start != n) rd = DW'($urandom);
            cyc++;
        end
        check("timeout", acc_cnt - start >= npix, 1);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
    endtask

    task automatic begin_test();
        got.delete();
        dut_fd = 0;
    endtask

    initial begin
        logic [9*DW-1:0] lw;
        do_reset();
        // directed frame, full throughput
        begin_test();
        run(NPIX, 0, 0, 0, 500);
        check("t1_count", got.size(), WPF);
        if (got.size() > 0) begin
            check("t1_first", got[0], 72'h12_11_10_0A_09_08_02_01_00);
            lw = got[got.size()-1];
            check("t1_last_centre", lw[4*DW +: DW], LAST_C);
        end
        check("t1_fd_cnt", dut_fd, 1);
        t1 = got;
        // downstream stall after the first window
        begin_test();
        run(NPIX, 0, 1, 0, 500);
        check("t2_count", got.size(), WPF);
        // input bubbles every other cycle
        begin_test();
        run(NPIX, 1, 0, 0, 500);
        check("t3_count", got.size(), WPF);
        for (int i = 0; i < got.size() && i < t1.size(); i++) check("t3_seq", got[i], t1[i]);
        check("t3_fd_cnt", dut_fd, 1);
        // reset mid-frame, then a clean frame
        begin_test();
        run(20, 0, 0, 0, 100);
        do_reset();
        begin_test();
        run(NPIX, 0, 0, 0, 500);
        check("t4_count", got.size(), WPF);
        if (got.size() > 0) check("t4_first", got[0], t1[0]);
        // two back-to-back frames, second offset by 0x40
        begin_test();
        run(2 * NPIX, 0, 0, 0, 1000);
        check("t5_count", got.size(), 2 * WPF);
        if (got.size() > WPF) check("t5_second_first", got[WPF], 72'h52_51_50_4A_49_48_42_41_40);
        check("t5_fd_cnt", dut_fd, 2);
        // random data, random valid and ready over several frames
        begin_test();
        run(4 * NPIX, 2, 2, 1, 4000);
        check("t6_count", got.size(), 4 * WPF);
        check("t6_fd_cnt", dut_fd, 4);
        check("final_queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
